// File: rtl/fp_mul_seq.sv
// Sequential IEEE-style multiplier (DAZ, RNE): radix-2 shift-add over FRAC_W+1 cycles, then normalise/round.
// out_valid rises FRAC_W+2 edges after acceptance; result is held in DONE until out_ready, in_ready only in IDLE.
module fp_mul_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    localparam int W     = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_operand,
    input  logic [W-1:0] b_operand,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         Exception,
    output logic         Overflow,
    output logic         Underflow
);

    localparam int M     = FRAC_W + 1;
    localparam int P_W   = 2 * M;
    localparam int CNT_W = $clog2(M) + 1;
    localparam int E_W   = EXP_W + 2;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [E_W-1:0] EXP_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]     a_q, b_q;
    logic [P_W-1:0]   prod_q;
    logic [CNT_W-1:0] cnt_q;

    // Operand field decode
    logic              a_sign, b_sign, res_sign;
    logic [EXP_W-1:0]  a_exp, b_exp, b_in_exp;
    logic [FRAC_W-1:0] a_frac, b_frac;
    logic [M-1:0]      a_sig;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_sign   = a_q[W-1];
    assign b_sign   = b_q[W-1];
    assign a_exp    = a_q[W-2:FRAC_W];
    assign b_exp    = b_q[W-2:FRAC_W];
    assign a_frac   = a_q[FRAC_W-1:0];
    assign b_frac   = b_q[FRAC_W-1:0];
    assign b_in_exp = b_operand[W-2:FRAC_W];
    assign a_sig    = {|a_exp, a_frac};
    assign res_sign = a_sign ^ b_sign;

    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == '1) && (a_frac == '0);
    assign b_inf  = (b_exp == '1) && (b_frac == '0);
    assign a_nan  = (a_exp == '1) && (a_frac != '0);
    assign b_nan  = (b_exp == '1) && (b_frac != '0);

    // Shift-add step: the LSB of prod_q is the current multiplier bit
    logic [M:0]     add_sum;
    logic [P_W-1:0] prod_step;

    assign add_sum   = {1'b0, prod_q[P_W-1:M]} + (prod_q[0] ? {1'b0, a_sig} : {(M+1){1'b0}});
    assign prod_step = {add_sum, prod_q[M-1:1]};

    // Normalise and round-to-nearest-even
    logic              norm;
    logic [P_W-1:0]    prod_n;
    logic [FRAC_W-1:0] frac_t;
    logic              guard, sticky, round_up, rnd_carry;
    logic [FRAC_W:0]   frac_sum;
    logic [E_W-1:0]    exp_u;
    logic signed [E_W-1:0] exp_s;

    assign norm      = prod_q[P_W-1];
    assign prod_n    = norm ? prod_q : {prod_q[P_W-2:0], 1'b0};
    assign frac_t    = prod_n[P_W-2 -: FRAC_W];
    assign guard     = prod_n[FRAC_W];
    assign sticky    = |prod_n[FRAC_W-1:0];
    assign round_up  = guard & (sticky | frac_t[0]);
    assign frac_sum  = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};
    assign rnd_carry = frac_sum[FRAC_W];
    assign exp_u     = {2'b00, a_exp} + {2'b00, b_exp} - E_W'(BIAS)
                     + E_W'(norm) + E_W'(rnd_carry);
    assign exp_s     = $signed(exp_u);

    logic [W-1:0] res_nxt;
    logic         exc_nxt, ovf_nxt, unf_nxt;

    always_comb begin
        res_nxt = {res_sign, exp_u[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
        exc_nxt = 1'b0;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res_nxt = QNAN;
            exc_nxt = 1'b1;
        end else if (a_inf || b_inf) begin
            res_nxt = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            res_nxt = {res_sign, {(W-1){1'b0}}};
        end else if (exp_s >= EXP_MAX) begin
            res_nxt = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_nxt = 1'b1;
        end else if (exp_s <= EXP_ZERO) begin
            res_nxt = {res_sign, {(W-1){1'b0}}};
            unf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_nxt = MUL;
            MUL:     if (cnt_q == CNT_W'(FRAC_W)) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            result    <= '0;
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a_operand;
                        b_q    <= b_operand;
                        prod_q <= {{M{1'b0}}, |b_in_exp, b_operand[FRAC_W-1:0]};
                        cnt_q  <= '0;
                    end
                end
                MUL: begin
                    prod_q <= prod_step;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                NORM: begin
                    result    <= res_nxt;
                    Exception <= exc_nxt;
                    Overflow  <= ovf_nxt;
                    Underflow <= unf_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (at least 3).
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width (at least 2); operand width W = 1+EXP_W+FRAC_W and BIAS = 2^(EXP_W-1)-1.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-004 clk  input  1  clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 a_operand  input  W  IEEE-style operand A {sign, exp, frac}.
REQ-009 b_operand  input  W  IEEE-style operand B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  W  product.
REQ-013 Exception  output  1  invalid operation; a NaN was produced.
REQ-014 Overflow  output  1  result saturated to infinity.
REQ-015 Underflow  output  1  result flushed to zero.

Function
REQ-016 SHALL be an FSM with states IDLE, MUL, NORM and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 In IDLE, an edge with in_valid=1 SHALL register both operands and move to MUL; the state SHALL stay IDLE otherwise.
REQ-018 MUL SHALL compute the (FRAC_W+1)x(FRAC_W+1) significand product by radix-2 shift-add, one multiplier bit per cycle, for exactly FRAC_W+1 cycles; it SHALL then move to NORM.
REQ-019 NORM SHALL normalise and round, register result and flags, and move to DONE; out_valid SHALL rise FRAC_W+2 edges after the accepting edge (25 at defaults); latency SHALL be constant for every operand class.
REQ-020 DONE SHALL hold result and flags stable until an edge with out_ready=1, then go to IDLE; in_ready SHALL be reasserted one cycle later, with no same-cycle bypass.
REQ-021 Operand changes while not in IDLE SHALL have no effect.
REQ-022 Sign SHALL be the XOR of the operand signs for every non-NaN result.
REQ-023 Exponent 0 (zero or subnormal) SHALL be treated as signed zero (denormals-are-zero).
REQ-024 Normalisation: if product bit 2*FRAC_W+1 is set, exponent SHALL be incremented; otherwise the product SHALL shift left by one.
REQ-025 Rounding SHALL be round-to-nearest-even using guard bit and sticky-OR; a rounding carry-out SHALL increment the exponent and zero the fraction.
REQ-026 Biased exponent SHALL be computed as ea+eb-BIAS+norm+carry in EXP_W+2 signed bits.
REQ-027 If the biased exponent is at least 2^EXP_W-1: result SHALL be signed infinity and Overflow=1.
REQ-028 If the biased exponent is at most 0: result SHALL be signed zero and Underflow=1.
REQ-029 Specials, highest priority first:
  - any NaN input, or infinity times zero: result {0, all-ones exp, fraction MSB 1, remaining bits 0}, Exception=1;
  - infinity times finite nonzero: signed infinity, all flags 0;
  - zero times finite: signed zero, all flags 0.
REQ-030 Only one of Exception, Overflow and Underflow SHALL be set for any result; flags SHALL be valid only while out_valid=1.

Reset
REQ-031 Reset SHALL force IDLE with in_ready=1, out_valid=0, and result, flags, product register and counter all 0, at any time including mid-MUL or in DONE; the in-flight operation SHALL be discarded with no output.
REQ-032 The first edge after reset deasserts SHALL be able to accept an operand pair.

Verification (defaults EXP_W=8, FRAC_W=23)
REQ-033 0x3FC00000 x 0x40000000 -> result 0x40400000, no flags, out_valid exactly 25 edges after acceptance.
REQ-034 0x3F800001 x 0x3FC00000 (tie case) -> 0x3FC00002, proving round-to-even rather than truncation.
REQ-035 0x7F7FFFFF x 0x40000000 -> 0x7F800000 with Overflow=1; 0x00800000 x 0x00800000 -> 0x00000000 with Underflow=1.
REQ-036 0x7F800000 x 0x80000000 -> 0x7FC00000 with Exception=1; 0xFF800000 x 0x40000000 -> 0xFF800000 with no flags; 0x80000000 x 0x3F800000 -> 0x80000000.
REQ-037 Hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0; back-to-back transactions SHALL give one result per acceptance, in order.
REQ-038 Assert reset at MUL cycle 10 -> out_valid=0 and in_ready=1 immediately; the next transaction SHALL produce a correct result.
